gray_img_server: RTL and testbench
==================================

// Module: gray_img_server
// PURPOSE
//  Responder for the gray-image read interface (gray_ready/gray_req/gray_addr/gray_data) used by IPF.
//  A host streams one frame into a single-port pixel RAM in raster order. The block then raises
//  gray_ready and serves registered reads until the consumer pulses finish. It then re-arms for the next frame.
//  Sits between the host/DMA loader and the IPF filter engine.
// PARAMETERS
//  In_Width    8   pixel width (bits)
//  Addr_Width  16  frame address width; frame = 2**Addr_Width pixels, addr = {row,col}
//  Cnt_Width   8   width of frame_cnt
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           async active-low reset
//  host_valid  in   1           host pixel valid
//  host_data   in   In_Width    host pixel, raster order
//  host_ready  out  1           block accepts host pixel this cycle
//  gray_ready  out  1           frame resident, reads allowed
//  gray_req    in   1           read request from consumer
//  gray_addr   in   Addr_Width  read address
//  gray_data   out  In_Width    read data, 1-cycle latency
//  finish      in   1           consumer done with frame (level or pulse)
//  rd_err      out  1           sticky: gray_req seen while not gray_ready
//  frame_cnt   out  Cnt_Width   frames fully loaded since reset, wraps
// BEHAVIOUR
//  Reset (rst_n=0, async): state=EMPTY; host_ready=0; gray_ready=0; gray_data=0.
//   rd_err=0; frame_cnt=0; load pointer wr_ptr=0. RAM contents are not reset.
//  States (2-bit): EMPTY=00, LOAD=01, READY=10. Code 11 is unused and recovers to EMPTY.
//  host_ready is combinational: 1 in EMPTY and LOAD, 0 in READY.
//  Accept = host_valid & host_ready. On accept: RAM[wr_ptr] <= host_data; wr_ptr <= wr_ptr+1 (wraps to 0).
//  EMPTY -> LOAD on an accept at wr_ptr=0.
//  LOAD -> READY on an accept at wr_ptr=2**Addr_Width-1.
//   In that same edge: frame_cnt += 1 (wraps); gray_ready goes 1 from the next cycle.
//  LOAD holds indefinitely while host_valid=0; there is no timeout.
//  READY -> EMPTY on finish=1. gray_ready drops in the next cycle. wr_ptr is already 0.
//  finish in EMPTY or LOAD is ignored. host_valid in READY is ignored (not accepted, no error).
//  gray_ready is a registered level: 1 iff state==READY.
//  Read: gray_req=1 & state==READY at edge t -> gray_data <= RAM[gray_addr], visible after edge t.
//   The consumer samples it in cycle t+1. Back-to-back reads are allowed every cycle.
//   The consumer may change gray_addr every cycle.
//  gray_data holds its last value when there is no valid read.
//  gray_req=1 while state!=READY: no RAM access, gray_data holds, rd_err <= 1 (sticky until reset).
//  finish and gray_req in the same cycle in READY: the read is served (gray_data updated) and state -> EMPTY.
//  Reading is allowed from any address in any order; the full address range is valid, so there is no range check.
//  The RAM is single-port. Writes occur only in EMPTY/LOAD and reads only in READY, so the two never collide.
//  Reset mid-load: wr_ptr returns to 0 and the partial frame is discarded.
//   The next load overwrites from address 0; frame_cnt is not incremented.
//  Reset while READY: gray_ready drops asynchronously; the host must reload.
// TESTING (bench uses Addr_Width=4, In_Width=8 -> 16-pixel frame)
//  1. Reset, stream 0x10..0x1F with host_valid=1 continuously.
//     -> gray_ready=1 one cycle after the 16th accept; frame_cnt=1; host_ready=0.
//  2. In READY, gray_req=1 with addr 0x3, 0x0, 0xF on consecutive cycles.
//     -> gray_data=0x13, 0x10, 0x1F one cycle after each; rd_err=0.
//  3. Load with host_valid toggling 1/0 every cycle.
//     -> 16 accepts over 31 cycles; contents match; frame_cnt increments once.
//  4. gray_req=1 in EMPTY with addr 0x5 -> gray_data unchanged, rd_err=1 and stays 1.
//  5. In READY, finish=1 together with gray_req at addr 0x7.
//     -> gray_data=0x17; next cycle gray_ready=0, host_ready=1; second frame 0xA0..0xAF loads, frame_cnt=2.
//  6. Assert rst_n=0 after 9 accepts, release, load a full frame of 0x55.
//     -> all 16 reads return 0x55; frame_cnt=1.

Source files
------------

// File: rtl/gray_img_server.sv
// Gray-image read server: loads one frame from the host into a single-port pixel RAM,
// then serves registered reads until the consumer signals finish.
module gray_img_server #(
    parameter int unsigned In_Width   = 8,
    parameter int unsigned Addr_Width = 16,
    parameter int unsigned Cnt_Width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_valid,
    input  logic [In_Width-1:0]   host_data,
    output logic                  host_ready,
    output logic                  gray_ready,
    input  logic                  gray_req,
    input  logic [Addr_Width-1:0] gray_addr,
    output logic [In_Width-1:0]   gray_data,
    input  logic                  finish,
    output logic                  rd_err,
    output logic [Cnt_Width-1:0]  frame_cnt
);

    localparam int unsigned Depth = 2 ** Addr_Width;
    localparam logic [Addr_Width-1:0] LastAddr = Addr_Width'(Depth - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [Addr_Width-1:0] wr_ptr_q, wr_ptr_d;
    logic [Cnt_Width-1:0]  frame_cnt_q, frame_cnt_d;
    logic [In_Width-1:0]   gray_data_q, gray_data_d;
    logic                  gray_ready_q, gray_ready_d;
    logic                  rd_err_q, rd_err_d;
    logic                  accept;
    logic                  mem_we;
    logic                  rd_en;

    logic [In_Width-1:0]   mem [Depth];

    // Held low during reset so the host never sees an accept before the block is live
    assign host_ready = rst_n & ((state_q == EMPTY) | (state_q == LOAD));
    assign accept     = host_valid & host_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        mem_we      = 1'b0;
        rd_en       = 1'b0;

        if (accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + Addr_Width'(1);
        end

        case (state_q)
            EMPTY: begin
                if (accept && (wr_ptr_q == '0)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && (wr_ptr_q == LastAddr)) begin
                    state_d     = READY;
                    frame_cnt_d = frame_cnt_q + Cnt_Width'(1);
                end
            end
            READY: begin
                rd_en = gray_req;
                if (finish) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d  = EMPTY;
                wr_ptr_d = '0;
            end
        endcase

        rd_err_d     = rd_err_q | (gray_req & (state_q != READY));
        gray_data_d  = rd_en ? mem[gray_addr] : gray_data_q;
        gray_ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            wr_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            gray_data_q  <= '0;
            gray_ready_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            gray_data_q  <= gray_data_d;
            gray_ready_q <= gray_ready_d;
            rd_err_q     <= rd_err_d;
        end
    end

    // Pixel storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= host_data;
        end
    end

    assign gray_ready = gray_ready_q;
    assign gray_data  = gray_data_q;
    assign rd_err     = rd_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_gray_img_server.sv
// Bench for gray_img_server with a 16-pixel frame: table-driven reads plus a read-data scoreboard.
module tb_gray_img_server;

    localparam int unsigned IW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned NPIX = 16;

    logic          clk;
    logic          rst_n;
    logic          host_valid;
    logic [IW-1:0] host_data;
    logic          host_ready;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [IW-1:0] gray_data;
    logic          finish;
    logic          rd_err;
    logic [CW-1:0] frame_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] exp_mem [NPIX];
    logic [IW-1:0] sb_q [$];
    logic [IW-1:0] last_data;
    logic [CW-1:0] exp_fcnt;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab [6];

    gray_img_server #(
        .In_Width  (IW),
        .Addr_Width(AW),
        .Cnt_Width (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_valid(host_valid),
        .host_data (host_data),
        .host_ready(host_ready),
        .gray_ready(gray_ready),
        .gray_req  (gray_req),
        .gray_addr (gray_addr),
        .gray_data (gray_data),
        .finish    (finish),
        .rd_err    (rd_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; results of reads driven before the edge are popped and compared after it
    task automatic tick();
        int n;
        n = sb_q.size();
        @(posedge clk);
        #1;
        if (n > 0) begin
            last_data = sb_q.pop_front();
            check("rd_data", 32'(gray_data), 32'(last_data));
        end
    endtask

    task automatic load_frame(input logic [IW-1:0] base, input bit inc, input bit toggle);
        for (int i = 0; i < int'(NPIX); i++) begin
            host_valid = 1'b1;
            host_data  = inc ? IW'(base + IW'(i)) : base;
            exp_mem[i] = host_data;
            if (i == 0 || i == int'(NPIX) - 1) begin
                check("ld_host_ready", 32'(host_ready), 32'(1));
                check("ld_gray_ready", 32'(gray_ready), 32'(0));
            end
            tick();
            if (toggle && i != int'(NPIX) - 1) begin
                host_valid = 1'b0;
                finish     = 1'b1;
                tick();
                finish     = 1'b0;
            end
        end
        host_valid = 1'b0;
        exp_fcnt   = exp_fcnt + CW'(1);
        check("ld_done_gray_ready", 32'(gray_ready), 32'(1));
        check("ld_done_host_ready", 32'(host_ready), 32'(0));
        check("ld_done_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    endtask

    task automatic read_all();
        for (int i = int'(NPIX) - 1; i >= 0; i--) begin
            gray_req  = 1'b1;
            gray_addr = AW'(i);
            sb_q.push_back(exp_mem[i]);
            tick();
        end
        gray_req = 1'b0;
    endtask

    initial begin
        rd_tab[0] = '{addr: 4'h3, exp: 8'h13};
        rd_tab[1] = '{addr: 4'h0, exp: 8'h10};
        rd_tab[2] = '{addr: 4'hF, exp: 8'h1F};
        rd_tab[3] = '{addr: 4'h8, exp: 8'h18};
        rd_tab[4] = '{addr: 4'h8, exp: 8'h18};
        rd_tab[5] = '{addr: 4'hC, exp: 8'h1C};

        rst_n = 1'b0; host_valid = 1'b0; host_data = '0;
        gray_req = 1'b0; gray_addr = '0; finish = 1'b0;
        last_data = '0; exp_fcnt = '0;

        // Reset state
        #12;
        check("rst_host_ready", 32'(host_ready), 32'(0));
        check("rst_gray_ready", 32'(gray_ready), 32'(0));
        check("rst_gray_data", 32'(gray_data), 32'(0));
        check("rst_rd_err", 32'(rd_err), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_host_ready", 32'(host_ready), 32'(1));

        // Continuous load 0x10..0x1F
        load_frame(8'h10, 1'b1, 1'b0);

        // Back-to-back reads from the table
        for (int i = 0; i < 6; i++) begin
            gray_req  = 1'b1;
            gray_addr = rd_tab[i].addr;
            sb_q.push_back(rd_tab[i].exp);
            tick();
        end
        gray_req = 1'b0;
        check("rd_err_clean", 32'(rd_err), 32'(0));

        // host_valid in READY is ignored
        host_valid = 1'b1; host_data = 8'hEE; gray_addr = 4'h0;
        tick();
        host_valid = 1'b0;
        check("ready_ignore_host", 32'(gray_ready), 32'(1));
        gray_req = 1'b1; gray_addr = 4'h0; sb_q.push_back(8'h10);
        tick();
        gray_req = 1'b0;

        // finish together with a read
        finish = 1'b1; gray_req = 1'b1; gray_addr = 4'h7; sb_q.push_back(8'h17);
        tick();
        finish = 1'b0; gray_req = 1'b0;
        check("fin_gray_ready", 32'(gray_ready), 32'(0));
        check("fin_host_ready", 32'(host_ready), 32'(1));
        check("fin_rd_err", 32'(rd_err), 32'(0));

        // Read while EMPTY: data holds, sticky error
        gray_req = 1'b1; gray_addr = 4'h5;
        tick();
        gray_req = 1'b0;
        check("empty_rd_hold", 32'(gray_data), 32'(last_data));
        check("empty_rd_err", 32'(rd_err), 32'(1));
        tick();
        tick();
        check("rd_err_sticky", 32'(rd_err), 32'(1));

        // Toggled load of 0xA0..0xAF, finish asserted in idle cycles
        load_frame(8'hA0, 1'b1, 1'b1);
        read_all();
        check("rd_err_still", 32'(rd_err), 32'(1));

        // Close the frame, start a partial load, reset mid-load
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 9; i++) begin
            host_valid = 1'b1; host_data = 8'h99;
            tick();
        end
        host_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midload_rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("midload_rst_rd_err", 32'(rd_err), 32'(0));
        check("midload_rst_gray_ready", 32'(gray_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_fcnt = '0;
        @(posedge clk);
        #1;

        // Full frame of 0x55 after the aborted load
        load_frame(8'h55, 1'b0, 1'b0);
        read_all();

        // Async reset while READY
        #2;
        rst_n = 1'b0;
        #1;
        check("ready_rst_gray_ready", 32'(gray_ready), 32'(0));
        check("ready_rst_host_ready", 32'(host_ready), 32'(0));
        check("ready_rst_gray_data", 32'(gray_data), 32'(0));
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
